// File: rtl/button_event_reader.sv
// ---------------------------------------------------------------------------
// button_event_reader
//
// Turns a word of per-button capture bits into a stream of button-index
// events. A nonzero capture word is snapshotted. Each snapshot bit is then
// scanned in ascending order, one bit per cycle. For every set bit the index
// is pushed into an event FIFO, and the matching capture bit is cleared with
// a single clr strobe. After the strobe, the block waits briefly for the
// cleared bits to drop before it takes another snapshot.
//
// Ports
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   data        : capture word; only bits [NUM_BUTTONS-1:0] are looked at
//   clr         : per-button capture-clear strobe (one cycle, in CLEAR only)
//   evt_valid   : FIFO head holds an event
//   evt_ready   : consumer takes the head event
//   evt_code    : button index of the head event (0 when the FIFO is empty)
//   overflow    : sticky, set when an event was dropped on a full FIFO
//   ovf_clr     : clears overflow on the next edge (a same-cycle drop wins)
//   busy        : FSM is anywhere but IDLE
//   fifo_count  : number of events held in the FIFO
// ---------------------------------------------------------------------------
module button_event_reader #(
  parameter int NUM_BUTTONS = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                                                     clk,
  input  logic                                                     rst_n,
  input  logic [DATA_WIDTH-1:0]                                    data,
  output logic [NUM_BUTTONS-1:0]                                   clr,
  output logic                                                     evt_valid,
  input  logic                                                     evt_ready,
  output logic [((NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1)-1:0] evt_code,
  output logic                                                     overflow,
  input  logic                                                     ovf_clr,
  output logic                                                     busy,
  output logic [$clog2(FIFO_DEPTH):0]                              fifo_count
);

  localparam int CODE_W = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [CODE_W-1:0] LAST_IDX   = CODE_W'(NUM_BUTTONS - 1);
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [1:0]        WAIT_LAST  = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    CLEAR,
    WAIT_DROP
  } state_t;

  state_t state, state_next;

  logic [NUM_BUTTONS-1:0] buttons;
  logic [NUM_BUTTONS-1:0] snap;
  logic [NUM_BUTTONS-1:0] done;
  logic [CODE_W-1:0]      idx;
  logic [1:0]             wait_cnt;

  logic [CODE_W-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;

  logic push_req;
  logic fifo_full;
  logic pop;
  logic push;
  logic drop;

  // The upper capture bits are ignored. They are still folded into a
  // throw-away net so the whole port is visibly consumed.
  logic unused_data;

  assign buttons     = data[NUM_BUTTONS-1:0];
  assign unused_data = ^data;

  // State register. Reset forces IDLE immediately, which also kills any clr
  // strobe, because clr is decoded only from the CLEAR state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and state-decoded outputs. A scan event is requested whenever
  // the snapshot bit under idx is set. WAIT_DROP gives up after its fourth
  // cycle, so a stuck capture bit cannot hang the reader.
  always_comb begin
    state_next = state;
    clr        = '0;
    busy       = 1'b1;
    push_req   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (buttons != '0) begin
          state_next = SCAN;
        end
      end
      SCAN: begin
        push_req = snap[idx];
        if (idx == LAST_IDX) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        clr        = done;
        state_next = WAIT_DROP;
      end
      WAIT_DROP: begin
        if (((buttons & done) == '0) || (wait_cnt == WAIT_LAST)) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Scan bookkeeping. done records which bits were handled in this pass,
  // including events dropped on a full FIFO. This lets CLEAR release every
  // bit that was seen. Bits that arrive after the snapshot are never in
  // done, so they survive the clear and are picked up by the next snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap     <= '0;
      done     <= '0;
      idx      <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (buttons != '0) begin
            snap <= buttons;
            done <= '0;
            idx  <= '0;
          end
        end
        SCAN: begin
          if (snap[idx]) begin
            done[idx] <= 1'b1;
          end
          if (idx != LAST_IDX) begin
            idx <= idx + CODE_W'(1);
          end
          wait_cnt <= '0;
        end
        CLEAR: begin
          wait_cnt <= '0;
        end
        WAIT_DROP: begin
          wait_cnt <= wait_cnt + 2'd1;
          if (state_next == IDLE) begin
            done <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // FIFO handshake. A pop in the same cycle frees the slot, so a push into
  // a full FIFO is accepted in that case. When the FIFO is empty there is no
  // valid head, so evt_ready has no effect there.
  assign fifo_full  = (count == FULL_COUNT);
  assign evt_valid  = (count != '0);
  assign pop        = evt_valid && evt_ready;
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;
  assign evt_code   = evt_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;

  // Event storage. The storage has no reset; the head is masked to zero
  // whenever the count says the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= idx;
    end
  end

  // Pointers wrap naturally because the depth is a power of two. The count
  // carries one extra bit so that it can represent a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow. A drop takes priority over a clear request in the same
  // cycle, so that a loss is never hidden.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_button_event_reader.sv
// ---------------------------------------------------------------------------
// tb_button_event_reader
//
// Bench for button_event_reader. A small capture-register model sits between
// the stimulus and the data port. It sets bits on request, clears them on the
// DUT clr strobe, and can hold bits stuck high. Expected event codes are
// queued when a capture is issued. A negedge monitor pops and compares them
// whenever the DUT hands over an event.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_button_event_reader;

  localparam int NB = 8;
  localparam int DW = 32;
  localparam int FD = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data;
  logic [NB-1:0] clr;
  logic          evt_valid;
  logic          evt_ready;
  logic [2:0]    evt_code;
  logic          overflow;
  logic          ovf_clr;
  logic          busy;
  logic [3:0]    fifo_count;

  logic [NB-1:0]    cap = '0;
  logic [NB-1:0]    set_mask;
  logic [NB-1:0]    stuck_mask;
  logic [DW-NB-1:0] upper_noise;

  logic [2:0] exp_q[$];
  logic [2:0] exp_code;
  int         compared   = 0;
  int         mismatched = 0;

  button_event_reader #(
    .NUM_BUTTONS(NB),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data      (data),
    .clr       (clr),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  // 10 ns clock; stimulus moves 2 ns after the rising edge, checks run on
  // the falling edge
  always #5 clk = ~clk;

  // External capture register: new presses set bits, the clr strobe clears them
  always @(posedge clk) cap <= (cap & ~clr) | set_mask;

  assign data = {upper_noise, cap | stuck_mask};

  // Scoreboard monitor: every accepted event must match the oldest expected code
  always @(negedge clk) begin
    if (rst_n === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL event_unexpected: got code %0d, nothing expected", evt_code);
      end else begin
        exp_code = exp_q.pop_front();
        if (evt_code !== exp_code) begin
          mismatched++;
          $display("[TB] FAIL event_code: got %0d, expected %0d", evt_code, exp_code);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expectEvents(input logic [NB-1:0] mask);
    for (int i = 0; i < NB; i++) begin
      if (mask[i]) exp_q.push_back(3'(i));
    end
  endtask

  // One-cycle press; returns in the cycle in which the DUT sees the capture bits
  task automatic pulseCapture(input logic [NB-1:0] mask);
    set_mask = mask;
    tick();
    set_mask = '0;
  endtask

  task automatic applyStimulus(input logic [NB-1:0] mask);
    expectEvents(mask);
    pulseCapture(mask);
  endtask

  // Bounded wait for busy to rise and then fall again
  task automatic waitRound(input string name);
    int  n;
    bit  seen;
    n    = 0;
    seen = 0;
    @(negedge clk);
    while (busy !== 1'b1 && n < 4) begin
      @(negedge clk);
      n++;
    end
    if (busy === 1'b1) seen = 1;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (!seen || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s_round: busy seen=%0d, final busy=%0b, required seen=1 busy=0",
               name, seen, busy);
    end
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (fifo_count !== 4'd0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_drained"}, 32'(fifo_count), 32'd0);
    checkOutput({name, "_queue_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    evt_ready   = 1'b0;
    ovf_clr     = 1'b0;
    set_mask    = '0;
    stuck_mask  = '0;
    upper_noise = '0;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_clr", 32'(clr), 32'd0);
    checkOutput("rst_evt_valid", 32'(evt_valid), 32'd0);
    checkOutput("rst_evt_code", 32'(evt_code), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
    tick();
    rst_n = 1'b1;

    // Upper capture bits must not start a scan
    upper_noise = 24'hA5A5A5;
    repeat (4) @(negedge clk);
    checkOutput("upper_bits_busy", 32'(busy), 32'd0);
    checkOutput("upper_bits_valid", 32'(evt_valid), 32'd0);

    // Scenario 1: 0x05 -> events 0, 2; clr=0x05 exactly at T+9
    tick();
    evt_ready = 1'b1;
    applyStimulus(8'h05);
    @(negedge clk);
    checkOutput("s1_busy_at_T", 32'(busy), 32'd0);
    repeat (8) @(negedge clk);
    checkOutput("s1_clr_T8", 32'(clr), 32'd0);
    checkOutput("s1_busy_T8", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("s1_clr_T9", 32'(clr), 32'h05);
    @(negedge clk);
    checkOutput("s1_clr_T10", 32'(clr), 32'd0);
    checkOutput("s1_data_dropped", 32'(data[NB-1:0]), 32'd0);
    @(negedge clk);
    checkOutput("s1_idle_T11", 32'(busy), 32'd0);
    checkOutput("s1_queue_empty", exp_q.size(), 32'd0);

    // Scenario 2: no consumer, ten single captures -> 8 stored, 2 dropped
    tick();
    evt_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i < 8) applyStimulus(8'(1 << (i % 8)));
      else       pulseCapture(8'(1 << (i % 8)));
      waitRound("s2");
      if (i == 7) begin
        checkOutput("s2_count_full", 32'(fifo_count), 32'd8);
        checkOutput("s2_no_ovf_yet", 32'(overflow), 32'd0);
      end
      if (i == 8) checkOutput("s2_ovf_first_drop", 32'(overflow), 32'd1);
    end
    checkOutput("s2_count_capped", 32'(fifo_count), 32'd8);
    repeat (3) @(negedge clk);
    checkOutput("s2_ovf_sticky", 32'(overflow), 32'd1);
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    @(negedge clk);
    checkOutput("s2_ovf_cleared", 32'(overflow), 32'd0);

    // Scenario 6: push into a full FIFO while popping -> no drop, order kept
    tick();
    applyStimulus(8'h01);
    tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    @(negedge clk);
    checkOutput("s6_count_stays", 32'(fifo_count), 32'd8);
    checkOutput("s6_no_drop", 32'(overflow), 32'd0);
    waitRound("s6");
    tick();
    evt_ready = 1'b1;
    waitDrain("s6");

    // Scenario 3: bit 1 snapshotted, bit 4 arrives mid-scan
    tick();
    applyStimulus(8'h02);
    tick();
    tick();
    applyStimulus(8'h10);
    repeat (7) @(negedge clk);
    checkOutput("s3_clr_only_bit1", 32'(clr), 32'h02);
    @(negedge clk);
    checkOutput("s3_bit4_kept", 32'(data[NB-1:0]), 32'h10);
    begin
      int n;
      n = 0;
      while (clr === '0 && n < 30) begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("s3_second_clr", 32'(clr), 32'h10);
    waitRound("s3");
    checkOutput("s3_data_clear", 32'(data[NB-1:0]), 32'd0);
    checkOutput("s3_queue_empty", exp_q.size(), 32'd0);

    // Scenario 4: bit 3 stuck high -> WAIT_DROP times out, the event repeats
    tick();
    expectEvents(8'h08);
    expectEvents(8'h08);
    stuck_mask = 8'h08;
    repeat (14) @(negedge clk);
    checkOutput("s4_wait_T13", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("s4_timeout_idle_T14", 32'(busy), 32'd0);
    tick();
    stuck_mask = '0;
    waitRound("s4");
    checkOutput("s4_queue_empty", exp_q.size(), 32'd0);

    // Scenario 5: reset in the third SCAN cycle with data=0xFF
    tick();
    evt_ready = 1'b0;
    tick();
    pulseCapture(8'hFF);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("s5_rst_clr", 32'(clr), 32'd0);
    checkOutput("s5_rst_valid", 32'(evt_valid), 32'd0);
    checkOutput("s5_rst_code", 32'(evt_code), 32'd0);
    checkOutput("s5_rst_busy", 32'(busy), 32'd0);
    checkOutput("s5_rst_count", 32'(fifo_count), 32'd0);
    checkOutput("s5_rst_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("s5_no_clr_in_rst", 32'(clr), 32'd0);
    end
    expectEvents(8'hFF);
    tick();
    rst_n = 1'b1;
    waitRound("s5");
    checkOutput("s5_rescan_count", 32'(fifo_count), 32'd8);
    checkOutput("s5_rescan_no_ovf", 32'(overflow), 32'd0);
    checkOutput("s5_data_cleared", 32'(data[NB-1:0]), 32'd0);
    tick();
    evt_ready = 1'b1;
    waitDrain("s5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/button_event_reader.md
BUTTON_EVENT_READER -- requirements
Module: button_event_reader

Interface
REQ-001 The block SHALL have parameter NUM_BUTTONS, default 8, giving the number of capture bits consumed (1..32).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of the capture word.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, giving the event FIFO depth; it SHALL be a power of 2 and at least 2.
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all logic SHALL be on its rising edge.
REQ-005 The block SHALL have port rst_n, input, width 1: the asynchronous, active-low reset.
REQ-006 The block SHALL have port data, input, width DATA_WIDTH: the capture word; only bits [NUM_BUTTONS-1:0] are used, and upper bits SHALL be ignored.
REQ-007 The block SHALL have port clr, output, width NUM_BUTTONS: per-button capture-clear strobes.
REQ-008 The block SHALL have port evt_valid, output, width 1: the FIFO head holds an event.
REQ-009 The block SHALL have port evt_ready, input, width 1: the consumer accepts the head event.
REQ-010 The block SHALL have port evt_code, output, width clog2(NUM_BUTTONS) (minimum 1): the button index of the head event.
REQ-011 The block SHALL have port overflow, output, width 1: a sticky flag set when an event is dropped because the FIFO is full.
REQ-012 The block SHALL have port ovf_clr, input, width 1: clears overflow.
REQ-013 The block SHALL have port busy, output, width 1: high whenever the FSM is not in IDLE.
REQ-014 The block SHALL have port fifo_count, output, width clog2(FIFO_DEPTH)+1: the FIFO occupancy.

Function
REQ-015 The FSM SHALL have the states IDLE, SCAN, CLEAR and WAIT_DROP.
REQ-016 In IDLE, when data[NUM_BUTTONS-1:0] is nonzero in cycle T, the block SHALL latch it into snap, reset idx to 0, and enter SCAN at T+1.
REQ-017 In SCAN, the block SHALL examine snap[idx] once per cycle, with idx running from 0 to NUM_BUTTONS-1, so SCAN lasts exactly NUM_BUTTONS cycles.
REQ-018 When snap[idx] is 1 in SCAN, the block SHALL push idx into the FIFO and set done[idx]; when the FIFO is full, the event SHALL be dropped, overflow SHALL be set, and done[idx] SHALL still be set.
REQ-019 After idx reaches NUM_BUTTONS-1, the FSM SHALL enter CLEAR, which lasts 1 cycle and drives clr = done; clr SHALL be 0 in every other state.
REQ-020 WAIT_DROP SHALL return to IDLE when (data[NUM_BUTTONS-1:0] & done) is 0, or after 4 cycles in WAIT_DROP (timeout), whichever comes first; done SHALL be cleared on exit.
REQ-021 Bits that become set in data after the snapshot SHALL NOT be cleared; they SHALL be caught by the next IDLE snapshot.
REQ-022 A push in SCAN at cycle C SHALL make the event visible on evt_valid/evt_code at C+1; there SHALL be no combinational bypass.
REQ-023 The FIFO SHALL pop when evt_valid and evt_ready are both 1; evt_ready SHALL be ignored when the FIFO is empty.
REQ-024 A simultaneous push and pop when the FIFO is full SHALL be accepted with no drop, and fifo_count SHALL be unchanged.
REQ-025 A simultaneous push and pop when the FIFO is empty SHALL perform the push only.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH.
REQ-027 Events SHALL be emitted in ascending index order within one snapshot and in snapshot order across snapshots.
REQ-028 ovf_clr SHALL clear overflow in the next cycle; when ovf_clr and a drop occur in the same cycle, overflow SHALL remain 1.
REQ-029 data SHALL be treated as synchronous to clk, and no synchronizer SHALL be included.

Reset
REQ-030 While rst_n is 0, the block SHALL force state to IDLE and set clr=0, evt_valid=0, evt_code=0, overflow=0, busy=0, fifo_count=0, and snap=done=idx=0.
REQ-031 Reset asserted mid-SCAN or mid-CLEAR SHALL abort the operation immediately, discard FIFO contents, and pulse no clr; after release, the block SHALL rescan any still-set capture bits from IDLE.
REQ-032 The block SHALL leave IDLE no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-033 Scenario 1: data=0x05, evt_ready=1 -> events 0 then 2, clr=0x05 for one cycle at T+9, data dropped to 0, then IDLE with busy=0.
REQ-034 Scenario 2: evt_ready=0, FIFO_DEPTH=8, ten successive single-button captures -> fifo_count=8, two drops, overflow=1 and stays 1 until ovf_clr.
REQ-035 Scenario 3: data bit 1 set at snapshot, bit 4 set during SCAN -> only clr[1] pulses; bit 4 produces a second snapshot and event 4.
REQ-036 Scenario 4: data bit stuck at 1 after clr -> WAIT_DROP times out after 4 cycles, and the next snapshot re-emits the event.
REQ-037 Scenario 5: rst_n pulsed low in the third SCAN cycle with data=0xFF -> all outputs 0 immediately, no clr pulse, and a full rescan after release.
REQ-038 Scenario 6: full FIFO with evt_ready=1 during a push -> no drop, fifo_count stays 8, and event order is preserved.
